calc_sequencer: RTL

//   Parametrised operator-entry sequencer for the two_fn_calculator family.

---
 rtl/calc_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
`timescale 1ns/1ps
// calc_sequencer
//   Operator-entry sequencer for the two_fn_calculator family. Conditions the
//   raw ENTER/CANCEL buttons into single-cycle press events, then steps the
//   datapath through NUM_OPS operand loads, a fixed-latency ALU execute,
//   result capture and display. A CANCEL press returns to IDLE from anywhere.
//   The debounce prescaler produces a clock-enable tick only; everything runs
//   on clk.
// Ports
//   clk        system clock
//   clr        asynchronous active-low reset
//   enter      raw ENTER button (async, bouncy, active-high)
//   cancel     raw CANCEL button (async, bouncy, active-high)
//   dp_rst_n   datapath reset, low only in IDLE
//   load_op    one-hot operand register load enable (LOAD)
//   op_idx     index of the operand being entered
//   alu_go     one-cycle ALU start strobe (first EXEC cycle)
//   load_res   one-cycle result load strobe, ALU_LAT cycles after alu_go
//   load_out   display register enable (SHOW)
//   busy       high in EXEC
//   state_code 00 IDLE, 01 LOAD, 10 EXEC, 11 SHOW
module calc_sequencer #(
  parameter int NUM_OPS        = 2,
  parameter int CLK_DIV        = 50,
  parameter int DEBOUNCE_TICKS = 6,
  parameter int ALU_LAT        = 1,
  localparam int IDXW          = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               enter,
  input  logic               cancel,
  output logic               dp_rst_n,
  output logic [NUM_OPS-1:0] load_op,
  output logic [IDXW-1:0]    op_idx,
  output logic               alu_go,
  output logic               load_res,
  output logic               load_out,
  output logic               busy,
  output logic [1:0]         state_code
);

  localparam int DIVW = $clog2(CLK_DIV);
  localparam int DBW  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int LATW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    EXEC = 2'b10,
    SHOW = 2'b11
  } state_t;

  // Button vectors: bit 0 = enter, bit 1 = cancel.
  logic [1:0]      raw_s;
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      deb_r;
  logic [1:0]      deb_d_r;
  logic [DBW-1:0]  stab_cnt_r [2];
  logic [1:0]      press_s;
  logic [DIVW-1:0] div_cnt_r;
  logic            tick_s;

  state_t              state_r;
  state_t              state_n;
  logic [IDXW-1:0]     idx_r;
  logic [IDXW-1:0]     idx_n;
  logic [LATW-1:0]     lat_r;
  logic [LATW-1:0]     lat_n;
  logic [NUM_OPS-1:0]  load_op_s;

  assign raw_s   = {cancel, enter};
  assign tick_s  = (div_cnt_r == DIVW'(CLK_DIV - 1));
  // A press is the cycle right after the debounced level rises.
  assign press_s = deb_r & ~deb_d_r;

  // Free-running sample prescaler shared by both buttons.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + 1'b1;
    end
  end

  // Synchronise both buttons and debounce them on sample ticks.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_r <= '0;
      sync2_r <= '0;
      deb_r   <= '0;
      deb_d_r <= '0;
      for (int b = 0; b < 2; b++) begin
        stab_cnt_r[b] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      for (int b = 0; b < 2; b++) begin
        if (tick_s) begin
          if (sync2_r[b] != deb_r[b]) begin
            // The tick that would make the count reach DEBOUNCE_TICKS flips the level.
            if (stab_cnt_r[b] == DBW'(DEBOUNCE_TICKS - 1)) begin
              deb_r[b]      <= ~deb_r[b];
              stab_cnt_r[b] <= '0;
            end else begin
              stab_cnt_r[b] <= stab_cnt_r[b] + 1'b1;
            end
          end else begin
            stab_cnt_r[b] <= '0;
          end
        end
      end
    end
  end

  // Sequencer state, operand index and ALU latency counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= IDLE;
      idx_r   <= '0;
      lat_r   <= '0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      lat_r   <= lat_n;
    end
  end

  // Next-state logic; cancel overrides any simultaneous enter.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    lat_n   = lat_r;
    if (press_s[1]) begin
      state_n = IDLE;
      idx_n   = '0;
      lat_n   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (press_s[0]) begin
            state_n = LOAD;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
        LOAD: begin
          if (press_s[0]) begin
            if (idx_r == IDXW'(NUM_OPS - 1)) begin
              state_n = EXEC;
              lat_n   = '0;
            end else begin
              idx_n = idx_r + 1'b1;
            end
          end else begin
            state_n = LOAD;
          end
        end
        EXEC: begin
          // Enter presses are dropped here; only the latency count moves.
          if (lat_r == LATW'(ALU_LAT)) begin
            state_n = SHOW;
            lat_n   = '0;
          end else begin
            lat_n = lat_r + 1'b1;
          end
        end
        SHOW: begin
          if (press_s[0]) begin
            state_n = LOAD;
            idx_n   = '0;
          end else begin
            state_n = SHOW;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          lat_n   = '0;
        end
      endcase
    end
  end

  // One-hot operand enable decoded from the next state.
  always_comb begin
    load_op_s = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      load_op_s[i] = (state_n == LOAD) && (idx_n == IDXW'(i));
    end
  end

  // Output flops load the decode of the next state, so they track state_r exactly.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dp_rst_n <= 1'b0;
      load_op  <= '0;
      alu_go   <= 1'b0;
      load_res <= 1'b0;
      load_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      dp_rst_n <= (state_n != IDLE);
      load_op  <= load_op_s;
      alu_go   <= (state_n == EXEC) && (lat_n == '0);
      load_res <= (state_n == EXEC) && (lat_n == LATW'(ALU_LAT));
      load_out <= (state_n == SHOW);
      busy     <= (state_n == EXEC);
    end
  end

  assign op_idx     = idx_r;
  assign state_code = state_r;

endmodule
